// File: rtl/route_share_arb_if.sv
// Beat interface between the per-region sources, the shared route channel and the far-side sink.
interface route_share_arb_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          req_valid;
    logic [4*DATA_W-1:0] req_data;
    logic [3:0]          req_ready;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic [1:0]          out_id;
    logic                out_ready;
    logic                busy;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );
endinterface

// File: rtl/route_share_arb.sv
// Round-robin arbiter over four requesters feeding a PIPE_STAGES-deep shared channel; a beat accepted at edge k
// is on out after edge k+PIPE_STAGES-1; a stalled output freezes every stage and drops all req_ready.
module route_share_arb #(
    parameter int DATA_W      = 8,
    parameter int PIPE_STAGES = 2
) (
    input logic              clk,
    input logic              rst_n,
    route_share_arb_if.slave bus
);
    typedef struct packed {
        logic              vld;
        logic [1:0]        id;
        logic [DATA_W-1:0] dat;
    } stage_t;

    stage_t     pipe [PIPE_STAGES];
    stage_t     in_beat;
    logic [1:0] ptr;
    logic [1:0] grant;
    logic [1:0] idx;
    logic       grant_vld;
    logic       advance;
    logic       busy_any;

    // Global stall: the channel only moves when the tail can drain.
    assign advance = bus.out_ready | ~pipe[PIPE_STAGES-1].vld;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        grant     = ptr;
        grant_vld = 1'b0;
        idx       = ptr;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (bus.req_valid[idx]) begin
                grant     = idx;
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        in_beat = '0;
        if (grant_vld) begin
            in_beat.vld = 1'b1;
            in_beat.id  = grant;
            in_beat.dat = bus.req_data[int'(grant) * DATA_W +: DATA_W];
        end
    end

    assign bus.req_ready = (rst_n & advance & grant_vld) ? (4'b0001 << grant) : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 2'd0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else if (advance) begin
            pipe[0] <= in_beat;
            for (int i = 1; i < PIPE_STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (grant_vld) begin
                ptr <= grant + 2'd1;
            end
        end
    end

    always_comb begin
        busy_any = 1'b0;
        for (int i = 0; i < PIPE_STAGES; i++) begin
            busy_any = busy_any | pipe[i].vld;
        end
    end

    assign bus.out_valid = pipe[PIPE_STAGES-1].vld;
    assign bus.out_data  = pipe[PIPE_STAGES-1].dat;
    assign bus.out_id    = pipe[PIPE_STAGES-1].id;
    assign bus.busy      = busy_any;
endmodule

// File: doc/route_share_arb.md
# route_share_arb

Round-robin arbiter and pipelined transport for one shared long-haul route channel. Up to four independent requesters, each with a valid/ready beat interface, share a single registered channel that crosses the floorplan. The channel has PIPE_STAGES flop stages, so it can span distant regions without limiting timing. The block sits between the per-region sources and the far-side sink; it tags each beat with its source index so the sink can demultiplex.

## Interface
Parameters:
- DATA_W, 8, payload width per beat (1..64)
- PIPE_STAGES, 2, number of register stages in the shared channel (1..4)

Ports:
- clk  in  1  single clock; all logic is on its rising edge
- rst_n  in  1  asynchronous, active-low reset; assertion is asynchronous, deassertion is synchronized outside this block
- req_valid  in  4  per-requester beat valid
- req_data  in  4*DATA_W  per-requester payload; requester i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  4  per-requester accept; at most one bit is high in any cycle
- out_valid  out  1  channel output beat valid
- out_data  out  DATA_W  channel output payload
- out_id  out  2  source index of the output beat
- out_ready  in  1  sink accept
- busy  out  1  high when any pipeline stage holds a valid beat

## Operation
- **Pipeline.** The channel is PIPE_STAGES stages. Each stage holds {valid, id, data}.
- **Advance.** The pipeline uses a global stall: advance = out_ready | ~out_valid.
  - When advance = 1, every stage shifts by one and stage 0 loads the granted beat, or a bubble if there is no request.
  - When advance = 0, every stage holds.
  - Bubbles are not collapsed. This is intentional for a fixed-latency route.
- **Arbitration.** The arbiter is a round-robin with a 2-bit priority pointer ptr.
  - grant = the first index i in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req_valid[i] = 1.
  - req_ready[i] = advance & req_valid[i] & (grant == i). This is combinational, and ready depends on valid.
  - A beat on requester i is transferred when req_valid[i] & req_ready[i].
- **Pointer update.**
  - On a transfer from index g, ptr <= (g + 1) mod 4; the 2-bit wrap from 3 goes to 0.
  - With no transfer, ptr holds.
  - A requester that holds valid is served within 4 accepted beats.
- **Outputs.** out_valid, out_data and out_id come directly from the last stage's flops.
  - busy = OR of all stage valid bits.
- **Requester protocol.**
  - Once a requester asserts valid, it must hold valid and data stable until its transfer.
  - Losing arbitration does not drop or alter the pending beat.
- **Reset.** Asynchronous, with these values:
  - All stage valid bits = 0, so out_valid = 0 and busy = 0.
  - out_data = 0 and out_id = 0.
  - ptr = 0.
  - req_ready = 0 while rst_n is low.
- **Reset mid-operation.** In-flight beats are discarded, with no partial output. The first grant after reset is the lowest asserted index.

## Timing
- **Latency.** A beat transferred at rising edge k appears on out_valid/out_data after edge k+PIPE_STAGES-1, i.e. it is visible during the cycle following that edge. This holds provided no stall occurs. Each stall cycle adds exactly one cycle.
- **Throughput.** One beat per cycle when out_ready is held at 1.
- **Backpressure (out_ready = 0 while out_valid = 1).**
  - All req_ready are 0.
  - Output data is held stable until the cycle in which out_ready is 1.
- **Simultaneous requests.** Exactly one grant per cycle. Non-granted requesters see req_ready = 0 in that cycle.
- **Pipeline full with out_ready low.** No beat is lost or overwritten. Occupancy never exceeds PIPE_STAGES.
- **Empty pipeline.** out_valid = 0 implies advance = 1, so requests are accepted even while out_ready = 0.

## Test plan
- **Reset values.** Hold rst_n = 0 with req_valid = 4'b1111. Required: req_ready = 0, out_valid = 0, busy = 0, out_id = 0. After release, the first grant goes to index 0.
- **Single requester latency.** PIPE_STAGES = 2, out_ready = 1. Requester 2 sends data 0xA5 at edge k. Required: out_valid = 1, out_data = 0xA5, out_id = 2 after edge k+1, for exactly one cycle.
- **Round-robin fairness.** All four requesters valid continuously, out_ready = 1. Required: out_id sequence 0,1,2,3,0,1,…, each requester receives 4 of 16 beats, and no req_ready bits overlap.
- **Pointer wrap and skip.** After a grant to 3, requesters 1 and 2 are valid. Required: grant goes to 1, then 2, then 1 (ptr wraps 3→0 and skips the idle 0).
- **Backpressure.** Pipeline full, out_ready = 0 for 5 cycles. Required: out_data is stable, req_ready = 0 for all 5 cycles, and no beat is lost. On release, beats are delivered in acceptance order with the correct ids.
- **Reset mid-stream.** Assert rst_n low while 2 beats are in flight. Required: out_valid drops to 0 immediately and asynchronously, no stale beat appears after release, and ptr = 0.
